// File: rtl/ss_scan_display.sv
// Four-digit multiplexed seven-segment driver. It snapshots the BCD digits once per frame and applies the pause-blink, dash and leading-zero rules.
// Latency: 1 cycle from scan position/shadow to pins. No backpressure: the scan is free-running and inputs are sampled only at frame end.
module ss_scan_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 125,
    parameter int LZB          = 1
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [3:0] dig1_in,
    input  logic [3:0] dig2_in,
    input  logic [3:0] dig3_in,
    input  logic [3:0] dig4_in,
    input  logic [1:0] mode,
    output logic [6:0] SEG_N,
    output logic       DP_N,
    output logic [3:0] DIG_N,
    output logic       frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_END  = CW'(GUARD);
    localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;
    localparam logic [6:0]    SEG_BLANK  = 7'h7F;

    logic [CW-1:0] scan_cntr_q, scan_cntr_d;
    logic [1:0]    slot_q, slot_d;
    logic [3:0]    sdig1_q, sdig2_q, sdig3_q, sdig4_q;
    logic [1:0]    smode_q;
    logic [FW-1:0] frame_cntr_q;
    logic          blink_on_q;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    dign_q, dign_d;
    logic          frame_start_q;

    logic       tick, snap, guard, blank_blink;
    logic [3:0] val;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        g = SEG_BLANK;
        case (v)
            4'd0: g = 7'b1000000;
            4'd1: g = 7'b1111001;
            4'd2: g = 7'b0100100;
            4'd3: g = 7'b0110000;
            4'd4: g = 7'b0011001;
            4'd5: g = 7'b0010010;
            4'd6: g = 7'b0000010;
            4'd7: g = 7'b1111000;
            4'd8: g = 7'b0000000;
            4'd9: g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    assign tick        = (scan_cntr_q == SCAN_LAST);
    assign snap        = tick && (slot_q == 2'd3);
    assign guard       = (scan_cntr_q < GUARD_END);
    assign blank_blink = (smode_q == 2'd1) && !blink_on_q;

    always_comb begin
        scan_cntr_d = tick ? '0 : scan_cntr_q + CW'(1);
        slot_d      = tick ? slot_q + 2'd1 : slot_q;

        val = sdig1_q;
        case (slot_q)
            2'd0: val = sdig1_q;
            2'd1: val = sdig2_q;
            2'd2: val = sdig3_q;
            2'd3: val = sdig4_q;
            default: val = sdig1_q;
        endcase

        // Priority: mode-change dashes, pause blank, leading-zero blank, invalid dash, glyph.
        seg_d = glyph(val);
        if (smode_q == 2'd3)
            seg_d = SEG_DASH;
        else if (blank_blink)
            seg_d = SEG_BLANK;
        else if ((LZB == 1) && (slot_q == 2'd3) && (sdig4_q == 4'd0))
            seg_d = SEG_BLANK;
        else if (val > 4'd9)
            seg_d = SEG_DASH;

        dign_d = guard ? 4'hF : ~(4'b0001 << slot_q);
        dp_d   = !((slot_q == 2'd2) && !guard && !blank_blink);
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            scan_cntr_q   <= '0;
            slot_q        <= 2'd0;
            sdig1_q       <= 4'd0;
            sdig2_q       <= 4'd0;
            sdig3_q       <= 4'd0;
            sdig4_q       <= 4'd0;
            smode_q       <= 2'd0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            dign_q        <= 4'hF;
        end else begin
            scan_cntr_q   <= scan_cntr_d;
            slot_q        <= slot_d;
            frame_start_q <= snap;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            dign_q        <= dign_d;
            if (snap) begin
                sdig1_q <= dig1_in;
                sdig2_q <= dig2_in;
                sdig3_q <= dig3_in;
                sdig4_q <= dig4_in;
                smode_q <= mode;
            end
        end
    end

    // The phase is held visible outside pause, so every pause begins visible.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            frame_cntr_q <= '0;
            blink_on_q   <= 1'b1;
        end else if (smode_q != 2'd1) begin
            frame_cntr_q <= '0;
            blink_on_q   <= 1'b1;
        end else if (snap) begin
            if (frame_cntr_q == BLINK_LAST) begin
                frame_cntr_q <= '0;
                blink_on_q   <= ~blink_on_q;
            end else begin
                frame_cntr_q <= frame_cntr_q + FW'(1);
            end
        end
    end

    assign SEG_N       = seg_q;
    assign DP_N        = dp_q;
    assign DIG_N       = dign_q;
    assign frame_start = frame_start_q;

endmodule
